port_out_uart_tx: RTL and testbench

//   Downstream consumer of the processor's 32-bit PortOut bus. Detects each new PortOut value,

---
 rtl/port_out_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_port_out_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_out_uart_tx.sv
// port_out_uart_tx
//   Watches the processor's 32-bit PortOut bus and queues every new value in a
//   small FIFO. Each queued word goes out on a single UART pin as four 8N1
//   bytes, most significant byte first. The result is a readable value trace
//   (typically the PC) on a serial terminal.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   FIFO_DEPTH    words buffered, power of two (2..16)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   PortData   in   [31:0] PortOut value from the processor
//   CaptureEn  in   1 = queue PortData whenever it changes
//   Tx         out  UART serial line, idles high
//   Busy       out  FIFO non-empty or a frame is in progress
//   Overflow   out  sticky, a word was dropped on a full FIFO
//   FifoCount  out  [4:0] words currently queued
module port_out_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PortData,
   input  logic        CaptureEn,
   output logic        Tx,
   output logic        Busy,
   output logic        Overflow,
   output logic [4:0]  FifoCount
);

   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t           state;
   logic [31:0]      prevData;
   logic [31:0]      fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [31:0]      shreg;
   logic [7:0]       curByte;
   logic [15:0]      bitTimer;
   logic [2:0]       bitIdx;
   logic [1:0]       byteIdx;
   logic             push;
   logic             pop;
   logic             full;
   logic             pushOk;
   logic             bitDone;

   assign push    = CaptureEn && (PortData != prevData);
   assign pop     = (state == LOAD);
   assign full    = (FifoCount == DEPTH_CNT);
   // A pop in the same cycle frees the head slot, so a push on a full FIFO
   // still lands (it writes the slot being read, which sees the old word).
   assign pushOk  = push && (!full || pop);
   assign bitDone = (bitTimer == BIT_LAST);
   assign Busy    = (FifoCount != 5'd0) || (state != IDLE);

   // Big-endian byte order on the wire.
   always_comb begin
      case (byteIdx)
         2'd0:    curByte = shreg[31:24];
         2'd1:    curByte = shreg[23:16];
         2'd2:    curByte = shreg[15:8];
         default: curByte = shreg[7:0];
      endcase
   end

   // Change detection and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         prevData  <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         FifoCount <= 5'd0;
         Overflow  <= 1'b0;
      end else begin
         prevData <= PortData;
         if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)    rdPtr <= rdPtr + PTR_W'(1);
         if (pushOk && !pop)      FifoCount <= FifoCount + 5'd1;
         else if (!pushOk && pop) FifoCount <= FifoCount - 5'd1;
         if (push && full && !pop) Overflow <= 1'b1;
      end
   end

   // FIFO storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (pushOk) fifoMem[wrPtr] <= PortData;
   end

   // Transmit FSM. Tx is loaded with the level of the state being entered, so
   // the line changes on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         Tx       <= 1'b1;
         bitTimer <= 16'd0;
         bitIdx   <= 3'd0;
         byteIdx  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               Tx <= 1'b1;
               if (FifoCount != 5'd0) state <= LOAD;
            end
            LOAD: begin
               shreg    <= fifoMem[rdPtr];
               byteIdx  <= 2'd0;
               bitTimer <= 16'd0;
               Tx       <= 1'b0;
               state    <= START;
            end
            START: begin
               if (bitDone) begin
                  bitTimer <= 16'd0;
                  bitIdx   <= 3'd0;
                  Tx       <= curByte[0];
                  state    <= DATA;
               end else begin
                  bitTimer <= bitTimer + 16'd1;
               end
            end
            DATA: begin
               if (bitDone) begin
                  bitTimer <= 16'd0;
                  if (bitIdx == 3'd7) begin
                     Tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx <= bitIdx + 3'd1;
                     Tx     <= curByte[bitIdx + 3'd1];
                  end
               end else begin
                  bitTimer <= bitTimer + 16'd1;
               end
            end
            STOP: begin
               if (bitDone) begin
                  bitTimer <= 16'd0;
                  if (byteIdx != 2'd3) begin
                     // Next byte follows the stop bit with no idle gap.
                     byteIdx <= byteIdx + 2'd1;
                     Tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     Tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  bitTimer <= bitTimer + 16'd1;
               end
            end
            default: begin
               Tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Testbench for port_out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A timestamp-based reference model predicts Tx, Busy, Overflow and FifoCount
// after every clock edge; directed sequences and a vector table cover the
// corner cases, followed by a randomized run.
module tb_port_out_uart_tx;
   localparam int C        = 4;
   localparam int D        = 4;
   localparam int WORD_CYC = 40 * C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PortData;
   logic        CaptureEn;
   logic        Tx;
   logic        Busy;
   logic        Overflow;
   logic [4:0]  FifoCount;

   int checks = 0;
   int errors = 0;

   port_out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .PortData(PortData), .CaptureEn(CaptureEn),
      .Tx(Tx), .Busy(Busy), .Overflow(Overflow), .FifoCount(FifoCount)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Frames are described by the edge they start on (pop edge) and end on;
   // the Tx level is derived from the offset into the 40-bit-time frame.
   logic [31:0] mq[$];
   logic [31:0] mPrev;
   logic [31:0] mWord;
   bit          mOvf  = 1'b0;
   bit          armed = 1'b0;
   longint      t      = 0;
   longint      fStart = 0;
   longint      fEnd   = 0;
   longint      loadAt = -1;
   logic        expTx;
   logic        expBusy;
   logic [4:0]  expCnt;

   function automatic logic frameBit(input longint off, input logic [31:0] w);
      int i, b, k;
      i = int'(off / C);
      b = i / 10;
      k = i % 10;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return w[8*(3-b) + k - 1];
   endfunction

   task automatic modelEdge();
      bit pushM, popM;
      int preSize;
      t++;
      if (reset === 1'b1) begin
         mq.delete();
         mPrev  = '0;
         mOvf   = 1'b0;
         fStart = t;
         fEnd   = t;
         loadAt = -1;
         armed  = 1'b1;
      end else begin
         preSize = mq.size();
         pushM   = CaptureEn && (PortData != mPrev);
         popM    = (loadAt == t);
         // Idle through the previous cycle with something queued: load next cycle.
         if (!popM && t > fEnd && loadAt < t && preSize > 0) loadAt = t + 1;
         if (popM) begin
            mWord  = mq.pop_front();
            fStart = t;
            fEnd   = t + WORD_CYC;
         end
         if (pushM) begin
            if (preSize < D || popM) mq.push_back(PortData);
            else mOvf = 1'b1;
         end
         mPrev = PortData;
      end
      expCnt  = 5'(mq.size());
      expTx   = (t >= fStart && t < fEnd) ? frameBit(t - fStart, mWord) : 1'b1;
      expBusy = (mq.size() != 0) || (t < fEnd) || (loadAt == t + 1);
   endtask

   initial forever begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      if (armed) begin
         chk("model_tx",    Tx,        expTx);
         chk("model_busy",  Busy,      expBusy);
         chk("model_ovf",   Overflow,  mOvf);
         chk("model_count", FifoCount, expCnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a negedge: drive inputs for the next edge, return at the following negedge.
   task automatic cyc(input logic [31:0] d, input logic c, input logic r);
      reset     = r;
      PortData  = d;
      CaptureEn = c;
      @(negedge clk);
   endtask

   task automatic hold();
      cyc(PortData, CaptureEn, 1'b0);
   endtask

   task automatic waitFall(input int limit, output longint tf, output bit ok);
      ok = 1'b0;
      tf = 0;
      for (int n = 0; n < limit; n++) begin
         if (Tx === 1'b0) begin
            ok = 1'b1;
            tf = t;
            return;
         end
         hold();
      end
   endtask

   task automatic waitIdle(input int limit, input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < limit; n++) begin
         if (Busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         hold();
      end
      chk(name, ok, 1'b1);
   endtask

   // Entered at the negedge after the start-bit edge; samples mid-bit.
   task automatic decodeWord(output logic [31:0] w, output bit framingOk);
      logic b;
      w = '0;
      framingOk = 1'b1;
      hold();
      for (int i = 0; i < 40; i++) begin
         b = Tx;
         if (i % 10 == 0) begin
            if (b !== 1'b0) framingOk = 1'b0;
         end else if (i % 10 == 9) begin
            if (b !== 1'b1) framingOk = 1'b0;
         end else begin
            w[8*(3 - i/10) + (i % 10) - 1] = b;
         end
         if (i < 39) repeat (C) hold();
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        cap;
      logic [4:0]  cnt;
      logic        ovf;
      logic        tx;
      logic        busy;
   } vec_t;

   vec_t        vecs[9];
   logic [31:0] w;
   logic [31:0] v3[3];
   bit          ok;
   bit          fr;
   longint      tf;
   longint      tprev;
   longint      tpush;
   int          peak;

   initial begin
      // Overflow burst from idle right after reset.
      vecs[0] = '{32'd1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{32'd2, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{32'd3, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{32'd4, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{32'd5, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'd6, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{32'd6, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{32'd7, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{32'd7, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1};

      reset = 1'b1; PortData = '0; CaptureEn = 1'b0;
      @(negedge clk);

      // 1. reset and quiet bus
      repeat (3) cyc(32'h0, 1'b0, 1'b1);
      chk("rst_ovf", Overflow, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(32'h0, 1'b1, 1'b0);
         chk("rst_tx", Tx, 1'b1);
         chk("rst_busy", Busy, 1'b0);
         chk("rst_count", FifoCount, 5'd0);
      end

      // 2. single word, latency and Busy release
      cyc(32'h0040_0004, 1'b1, 1'b0);
      chk("t2_tx_edge0", Tx, 1'b1);
      hold();
      chk("t2_tx_edge1", Tx, 1'b1);
      hold();
      chk("t2_tx_fall", Tx, 1'b0);
      decodeWord(w, fr);
      chk("t2_word", w, 32'h0040_0004);
      chk("t2_framing", fr, 1'b1);
      hold(); hold();
      chk("t2_busy_last", Busy, 1'b1);
      hold();
      chk("t2_busy_drop", Busy, 1'b0);

      // 3. three words queued behind a frame in flight
      v3[0] = 32'h1122_3344; v3[1] = 32'hA5A5_0F0F; v3[2] = 32'hDEAD_BEEF;
      cyc(32'hC0FF_EE00, 1'b1, 1'b0);
      hold();
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(v3[i], 1'b1, 1'b0);
         chk("t3_count_rise", FifoCount, 5'(i + 1));
         if (int'(FifoCount) > peak) peak = int'(FifoCount);
      end
      chk("t3_peak", 32'(peak), 32'd3);
      repeat (WORD_CYC - 4) hold();
      tprev = 0;
      for (int k = 0; k < 3; k++) begin
         waitFall(400, tf, ok);
         chk("t3_fall_seen", ok, 1'b1);
         if (k > 0) chk("t3_word_spacing", 32'(tf - tprev), 32'(WORD_CYC + 2));
         tprev = tf;
         decodeWord(w, fr);
         chk("t3_word", w, v3[k]);
         chk("t3_framing", fr, 1'b1);
      end
      chk("t3_ovf", Overflow, 1'b0);
      waitIdle(50, "t3_idle");

      // 4. overflow (vector table), sticky until reset
      repeat (2) cyc(32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cyc(vecs[i].data, vecs[i].cap, 1'b0);
         chk("t4_count", FifoCount, vecs[i].cnt);
         chk("t4_ovf", Overflow, vecs[i].ovf);
         chk("t4_tx", Tx, vecs[i].tx);
         chk("t4_busy", Busy, vecs[i].busy);
      end
      waitIdle(1500, "t4_drain");
      chk("t4_ovf_sticky", Overflow, 1'b1);
      cyc(32'h0, 1'b0, 1'b1);
      chk("t4_ovf_cleared", Overflow, 1'b0);

      // 5. push lands on the LOAD cycle with the FIFO full
      cyc(32'h0BAD_F00D, 1'b1, 1'b0);
      repeat (10) hold();
      cyc(32'h1000_0001, 1'b1, 1'b0);
      cyc(32'h2000_0002, 1'b1, 1'b0);
      cyc(32'h3000_0003, 1'b1, 1'b0);
      cyc(32'h4000_0004, 1'b1, 1'b0);
      chk("t5_full", FifoCount, 5'd4);
      repeat (149) hold();
      chk("t5_pre_count", FifoCount, 5'd4);
      chk("t5_pre_tx", Tx, 1'b1);
      cyc(32'h5000_0005, 1'b1, 1'b0);
      chk("t5_count_kept", FifoCount, 5'd4);
      chk("t5_ovf", Overflow, 1'b0);
      chk("t5_start", Tx, 1'b0);
      waitIdle(1500, "t5_drain");
      chk("t5_ovf_after", Overflow, 1'b0);

      // 6. reset during data bit 3 of the second byte
      cyc(32'h12F0_5634, 1'b1, 1'b0);
      for (int i = 1; i <= 58; i++) cyc((i >= 5) ? 32'h7777_0001 : 32'h12F0_5634, 1'b1, 1'b0);
      chk("t6_pre_tx", Tx, 1'b0);
      chk("t6_pre_count", FifoCount, 5'd1);
      cyc(32'h7777_0001, 1'b1, 1'b1);
      chk("t6_rst_tx", Tx, 1'b1);
      chk("t6_rst_count", FifoCount, 5'd0);
      chk("t6_rst_ovf", Overflow, 1'b0);
      chk("t6_rst_busy", Busy, 1'b0);
      cyc(32'h8421_C3E7, 1'b1, 1'b0);
      tpush = t;
      waitFall(10, tf, ok);
      chk("t6_fall_seen", ok, 1'b1);
      chk("t6_latency", 32'(tf - tpush), 32'd2);
      decodeWord(w, fr);
      chk("t6_word", w, 32'h8421_C3E7);
      chk("t6_framing", fr, 1'b1);
      waitIdle(50, "t6_idle");

      // 7. capture disabled
      for (int i = 0; i < 10; i++) begin
         cyc($urandom() ^ PortData, 1'b0, 1'b0);
         chk("t7_count", FifoCount, 5'd0);
         chk("t7_tx", Tx, 1'b1);
      end

      // 8. randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0)
            cyc(PortData, CaptureEn, 1'b1);
         else if ($urandom_range(0, 99) < 35)
            cyc(($urandom_range(0, 3) == 0) ? 32'(mPrev) : $urandom(),
                ($urandom_range(0, 99) < 85), 1'b0);
         else
            cyc(PortData, ($urandom_range(0, 99) < 85), 1'b0);
      end
      cyc(PortData, 1'b0, 1'b0);
      waitIdle(1500, "t8_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
